// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds size defaults, FSM state encoding and branch-select encoding.
package pc_sequencer_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int RAS_DEPTH_DEF = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // Winning strobe after priority resolution.
    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_RET = 3'd1,
        SEL_JMP = 3'd2,
        SEL_BRA = 3'd3,
        SEL_BRZ = 3'd4,
        SEL_BRN = 3'd5,
        SEL_BRC = 3'd6,
        SEL_BRO = 3'd7
    } sel_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address stack: synchronous push/pop, combinational top-of-stack.
// Ports: clk, rst, push, pop, din -> top, level, full, empty.
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int W     = PC_W_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int LW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [LW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [LW:0] FULL_LVL = (LW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] wr_idx;
    logic [LW-1:0] top_idx;

    assign wr_idx  = level[LW-1:0];
    // At level == DEPTH the low bits wrap to 0, so minus one still
    // lands on the last slot.
    assign top_idx = level[LW-1:0] - LW'(1);
    assign top     = mem[top_idx];
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);

    // Contents are not reset; level = 0 makes them unreachable.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + 1'b1;
        end else if (pop && !empty) begin
            level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority branch select, call/return stack, fault FSM.
// Ports: clk, rst, stall, strobes, flags, target -> pc, redirect, fault, ras_level.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEF,
    parameter int              RAS_DEPTH    = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       brz,
    input  logic                       brn,
    input  logic                       brc,
    input  logic                       bro,
    input  logic                       bra,
    input  logic                       jmp,
    input  logic                       ret,
    input  logic                       flag_z,
    input  logic                       flag_n,
    input  logic                       flag_c,
    input  logic                       flag_o,
    input  logic [PC_W-1:0]            target,
    output logic [PC_W-1:0]            pc,
    output logic                       redirect,
    output logic                       fault,
    output logic [$clog2(RAS_DEPTH):0] ras_level
);

    state_t          state;
    state_t          state_nxt;
    sel_t            sel;
    logic            cond;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] ras_top;
    logic            redirect_nxt;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;

    assign pc_inc = pc + 1'b1;
    assign fault  = (state == ST_FAULT);

    always_comb begin
        sel = SEL_SEQ;
        priority case (1'b1)
            ret:     sel = SEL_RET;
            jmp:     sel = SEL_JMP;
            bra:     sel = SEL_BRA;
            brz:     sel = SEL_BRZ;
            brn:     sel = SEL_BRN;
            brc:     sel = SEL_BRC;
            bro:     sel = SEL_BRO;
            default: sel = SEL_SEQ;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (sel)
            SEL_BRZ: cond = flag_z;
            SEL_BRN: cond = flag_n;
            SEL_BRC: cond = flag_c;
            SEL_BRO: cond = flag_o;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        redirect_nxt = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        if (state == ST_RUN && !stall) begin
            unique case (sel)
                SEL_RET: begin
                    if (empty) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        pop          = 1'b1;
                        pc_nxt       = ras_top;
                        redirect_nxt = 1'b1;
                    end
                end
                SEL_JMP: begin
                    if (full) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        push         = 1'b1;
                        pc_nxt       = target;
                        redirect_nxt = 1'b1;
                    end
                end
                SEL_BRA: begin
                    pc_nxt       = target;
                    redirect_nxt = 1'b1;
                end
                SEL_BRZ, SEL_BRN, SEL_BRC, SEL_BRO: begin
                    pc_nxt       = cond ? target : pc_inc;
                    redirect_nxt = cond;
                end
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_VECTOR;
            redirect <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            redirect <= redirect_nxt;
        end
    end

    return_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ras_top),
        .level (ras_level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a reference model and scoreboard.
// Drives directed scenarios then random strobes; prints one summary line.
module tb_pc_sequencer;

    localparam logic [6:0] S_RET = 7'b1000000;
    localparam logic [6:0] S_JMP = 7'b0100000;
    localparam logic [6:0] S_BRA = 7'b0010000;
    localparam logic [6:0] S_BRZ = 7'b0001000;
    localparam logic [6:0] S_BRN = 7'b0000100;
    localparam logic [6:0] S_BRC = 7'b0000010;
    localparam logic [6:0] S_BRO = 7'b0000001;
    localparam logic [3:0] F_Z   = 4'b1000;
    localparam logic [3:0] F_N   = 4'b0100;
    localparam logic [3:0] F_C   = 4'b0010;
    localparam logic [3:0] F_O   = 4'b0001;

    typedef struct packed {
        logic [9:0] pc;
        logic       red;
        logic       flt;
        logic [3:0] lvl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       brz, brn, brc, bro, bra, jmp, ret;
    logic       flag_z, flag_n, flag_c, flag_o;
    logic [9:0] target;
    logic [9:0] pc;
    logic       redirect;
    logic       fault;
    logic [3:0] ras_level;

    int n_chk;
    int n_err;

    exp_t       sb_q[$];
    logic [9:0] m_pc;
    logic [9:0] m_stk [8];
    int         m_lvl;
    logic       m_flt;
    logic       m_red;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .brz       (brz),
        .brn       (brn),
        .brc       (brc),
        .bro       (bro),
        .bra       (bra),
        .jmp       (jmp),
        .ret       (ret),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_o    (flag_o),
        .target    (target),
        .pc        (pc),
        .redirect  (redirect),
        .fault     (fault),
        .ras_level (ras_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference model step for the inputs currently driven.
    task automatic model();
        logic hit;
        if (rst) begin
            m_pc  = 10'h000;
            m_lvl = 0;
            m_flt = 1'b0;
            m_red = 1'b0;
        end else begin
            m_red = 1'b0;
            if (!m_flt && !stall) begin
                if (ret) begin
                    if (m_lvl == 0) begin
                        m_flt = 1'b1;
                    end else begin
                        m_lvl = m_lvl - 1;
                        m_pc  = m_stk[m_lvl];
                        m_red = 1'b1;
                    end
                end else if (jmp) begin
                    if (m_lvl == 8) begin
                        m_flt = 1'b1;
                    end else begin
                        m_stk[m_lvl] = m_pc + 10'd1;
                        m_lvl = m_lvl + 1;
                        m_pc  = target;
                        m_red = 1'b1;
                    end
                end else if (bra) begin
                    m_pc  = target;
                    m_red = 1'b1;
                end else if (brz || brn || brc || bro) begin
                    if (brz)      hit = flag_z;
                    else if (brn) hit = flag_n;
                    else if (brc) hit = flag_c;
                    else          hit = flag_o;
                    m_pc  = hit ? target : m_pc + 10'd1;
                    m_red = hit;
                end else begin
                    m_pc = m_pc + 10'd1;
                end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model();
        sb_q.push_back('{pc: m_pc, red: m_red, flt: m_flt,
                         lvl: 4'(m_lvl)});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("redirect", redirect, e.red);
            chk("fault", fault, e.flt);
            chk("ras_level", ras_level, e.lvl);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] f,
                         input logic [9:0] t, input logic st);
        {ret, jmp, bra, brz, brn, brc, bro} = s;
        {flag_z, flag_n, flag_c, flag_o} = f;
        target = t;
        stall  = st;
        rst    = 1'b0;
        cycle();
    endtask

    task automatic idle();
        drive(7'd0, 4'd0, 10'h000, 1'b0);
    endtask

    task automatic do_reset();
        {ret, jmp, bra, brz, brn, brc, bro} = 7'h7F;
        stall = 1'b1;
        rst   = 1'b1;
        cycle();
        rst   = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_pc  = 10'h000;
        m_lvl = 0;
        m_flt = 1'b0;
        m_red = 1'b0;
        {flag_z, flag_n, flag_c, flag_o} = 4'd0;
        target = 10'h000;

        do_reset();
        chk("rst_pc", pc, 10'h000);
        chk("rst_lvl", ras_level, 4'd0);
        chk("rst_fault", fault, 1'b0);
        repeat (4) idle();
        chk("idle_pc", pc, 10'h004);
        idle();

        drive(S_BRZ, 4'd0, 10'h040, 1'b0);
        chk("brz_nt_pc", pc, 10'h006);
        chk("brz_nt_red", redirect, 1'b0);
        drive(S_BRZ, F_Z, 10'h040, 1'b0);
        chk("brz_t_pc", pc, 10'h040);
        chk("brz_t_red", redirect, 1'b1);
        idle();
        chk("brz_red_drop", redirect, 1'b0);

        do_reset();
        repeat (16) idle();
        chk("at_10", pc, 10'h010);
        drive(S_JMP, 4'd0, 10'h080, 1'b0);
        chk("call_pc", pc, 10'h080);
        chk("call_lvl", ras_level, 4'd1);
        drive(S_RET, 4'd0, 10'h000, 1'b0);
        chk("ret_pc", pc, 10'h011);
        chk("ret_lvl", ras_level, 4'd0);

        drive(S_BRN, F_N, 10'h030, 1'b0);
        drive(S_BRN, 4'd0, 10'h050, 1'b0);
        chk("brn_nt", pc, 10'h031);
        drive(S_BRC, F_C, 10'h060, 1'b0);
        drive(S_BRC, F_Z | F_N | F_O, 10'h070, 1'b0);
        chk("brc_nt", pc, 10'h061);
        drive(S_BRO, F_O, 10'h090, 1'b0);
        chk("bro_t", pc, 10'h090);
        drive(S_BRO, F_C, 10'h099, 1'b0);
        drive(S_BRZ, F_Z, 10'h092, 1'b0);
        chk("tgt_inc_red", redirect, 1'b1);
        drive(S_BRA | S_BRZ, 4'd0, 10'h1A0, 1'b0);
        chk("bra_pri", pc, 10'h1A0);
        drive(S_BRZ | S_BRN, F_N, 10'h2A0, 1'b0);
        chk("brz_over_brn", pc, 10'h1A1);
        drive(S_JMP, 4'd0, 10'h200, 1'b0);
        drive(S_RET | S_JMP, 4'd0, 10'h300, 1'b0);
        chk("retjmp_pc", pc, 10'h1A2);
        chk("retjmp_lvl", ras_level, 4'd0);

        drive(S_RET, 4'd0, 10'h000, 1'b0);
        chk("uflow_fault", fault, 1'b1);
        chk("uflow_pc", pc, 10'h1A2);
        drive(S_JMP, F_Z, 10'h123, 1'b0);
        drive(S_BRA, 4'd0, 10'h124, 1'b0);
        chk("uflow_hold", pc, 10'h1A2);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(S_JMP, 4'd0, 10'(10'h100 + i * 16), 1'b0);
        end
        chk("oflow_fault", fault, 1'b1);
        chk("oflow_pc", pc, 10'h170);
        chk("oflow_lvl", ras_level, 4'd8);
        drive(S_RET, 4'd0, 10'h000, 1'b0);
        idle();
        chk("oflow_hold", pc, 10'h170);
        do_reset();
        chk("oflow_rst_pc", pc, 10'h000);
        chk("oflow_rst_flt", fault, 1'b0);

        repeat (2) idle();
        repeat (3) drive(S_JMP, 4'd0, 10'h055, 1'b1);
        chk("stall_pc", pc, 10'h002);
        chk("stall_lvl", ras_level, 4'd0);
        drive(S_JMP, 4'd0, 10'h055, 1'b0);
        chk("unstall_pc", pc, 10'h055);
        chk("unstall_lvl", ras_level, 4'd1);

        drive(S_BRA, 4'd0, 10'h3FF, 1'b0);
        idle();
        chk("wrap_pc", pc, 10'h000);
        chk("wrap_red", redirect, 1'b0);
        drive(S_BRA, 4'd0, 10'h3FF, 1'b0);
        drive(S_JMP, 4'd0, 10'h020, 1'b0);
        drive(S_RET, 4'd0, 10'h000, 1'b0);
        chk("wrap_ret_pc", pc, 10'h000);
        chk("wrap_ret_lvl", ras_level, 4'd1);

        for (int i = 0; i < 400; i++) begin
            if ((m_flt && ($urandom_range(0, 3) == 0))
                || ($urandom_range(0, 99) == 0)) begin
                do_reset();
            end else begin
                drive(7'($urandom) & 7'($urandom),
                      4'($urandom), 10'($urandom),
                      ($urandom_range(0, 7) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
